// File: rtl/ysyx_23060042_alu_pkg.sv
// rtl/ysyx_23060042_alu_pkg.sv - shared ALU opcode and arbiter state definitions
package ysyx_23060042_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    SLL  = 3'b010,
    SRL  = 3'b011,
    OR   = 3'b100,
    XOR  = 3'b101,
    AND  = 3'b110,
    SLTU = 3'b111
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ysyx_23060042_alu_arbiter_if.sv
// rtl/ysyx_23060042_alu_arbiter_if.sv - requester and shared-ALU signal bundle for the ALU arbiter
// Requester side : req_valid/req_ready/req_op/req_a/req_b, resp_valid/resp_ready/resp_data
// ALU side       : alu_op/alu_a/alu_b (to ALU), alu_out (from ALU, same cycle)
// Status         : busy
// slave  = arbiter view, master = requesters plus ALU view
interface ysyx_23060042_alu_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*OP_W-1:0]   req_op;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        resp_valid;
  logic [N_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]       resp_data;
  logic [OP_W-1:0]         alu_op;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [DATA_W-1:0]       alu_out;
  logic                    busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data, alu_op, alu_a, alu_b, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data, alu_op, alu_a, alu_b, busy
  );
endinterface

// File: rtl/ysyx_23060042_rr_picker.sv
// rtl/ysyx_23060042_rr_picker.sv - combinational round-robin picker
// req_i     : request vector
// ptr_i     : highest-priority index for this scan
// gnt_o     : one-hot grant
// gnt_idx_o : index of the granted request
// any_gnt_o : at least one request was granted
module ysyx_23060042_rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             any_gnt_o
);

  always_comb begin
    int c;
    c         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    // Scan from ptr_i upward, wrapping; the first set request wins.
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      if (!any_gnt_o && req_i[c]) begin
        any_gnt_o = 1'b1;
        gnt_o[c]  = 1'b1;
        gnt_idx_o = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060042_alu_arbiter.sv
// rtl/ysyx_23060042_alu_arbiter.sv - round-robin sharing of one combinational ALU between requesters
// clk   : clock, all state on rising edge
// rst_n : synchronous active-low reset
// bus   : requester request/response channels and the shared-ALU drive/return (slave view)
module ysyx_23060042_alu_arbiter
  import ysyx_23060042_alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = XLEN,
  parameter int OP_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_23060042_alu_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_RESP = 1'(RESP);

  logic [0:0]        state_q,     state_d;
  logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [PTR_W-1:0]  resp_id_q,   resp_id_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic              resp_fire;
  logic              window_open;
  logic [N_REQ-1:0]  pick_req;
  logic [N_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  resp_valid_oh;

  // The held result is consumed this cycle; a new grant may issue in the
  // same cycle so back-to-back ops sustain one per clock.
  assign resp_fire   = (state_q == ST_RESP) && bus.resp_ready[resp_id_q];
  assign window_open = (state_q == ST_IDLE) || resp_fire;
  assign pick_req    = window_open ? bus.req_valid : '0;

  ysyx_23060042_rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i     (pick_req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .any_gnt_o (pick_any)
  );

  assign bus.req_ready = pick_gnt;
  // ALU inputs are zeroed when nobody is granted so the shared ALU sees a
  // quiet bus outside grant cycles.
  assign bus.alu_op = pick_any ? bus.req_op[int'(pick_idx)*OP_W +: OP_W]     : '0;
  assign bus.alu_a  = pick_any ? bus.req_a[int'(pick_idx)*DATA_W +: DATA_W]  : '0;
  assign bus.alu_b  = pick_any ? bus.req_b[int'(pick_idx)*DATA_W +: DATA_W]  : '0;

  always_comb begin
    resp_valid_oh = '0;
    if (state_q == ST_RESP) resp_valid_oh[resp_id_q] = 1'b1;
  end

  assign bus.resp_valid = resp_valid_oh;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = (state_q == ST_RESP);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    if (pick_any) begin
      state_d     = ST_RESP;
      resp_id_d   = pick_idx;
      resp_data_d = bus.alu_out;
      rr_ptr_d    = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end else if (resp_fire) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_alu_arbiter.sv
// tb/tb_ysyx_23060042_alu_arbiter.sv - self-checking bench for the ALU arbiter
module tb_ysyx_23060042_alu_arbiter;
  import ysyx_23060042_alu_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = 3;

  logic clk;
  logic rst_n;

  ysyx_23060042_alu_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) bus ();

  ysyx_23060042_alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return a << b[4:0];
      SRL:     return a >> b[4:0];
      OR:      return a | b;
      XOR:     return a ^ b;
      AND:     return a & b;
      default: return {31'b0, (a < b)};
    endcase
  endfunction

  // Environment ALU sitting outside the arbiter.
  always_comb bus.alu_out = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: whether a result is held, for whom, its value, next priority.
  bit          m_held;
  int          m_id;
  int          m_ptr;
  logic [31:0] m_data;
  int          last_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pick();
    bit open;
    int w;
    open = !m_held || bus.resp_ready[m_id];
    w = -1;
    if (open)
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    return w;
  endfunction

  task automatic step();
    int w;
    logic [31:0] e_rdy, e_op, e_a, e_b, e_rv;
    @(negedge clk);
    w = ref_pick();
    e_rdy = 0; e_op = 0; e_a = 0; e_b = 0;
    if (w >= 0) begin
      e_rdy[w] = 1'b1;
      e_op = 32'(bus.req_op[w*OW +: OW]);
      e_a  = bus.req_a[w*DW +: DW];
      e_b  = bus.req_b[w*DW +: DW];
    end
    e_rv = 0;
    if (m_held) e_rv[m_id] = 1'b1;
    chk("req_ready",  32'(bus.req_ready),  e_rdy);
    chk("alu_op",     32'(bus.alu_op),     e_op);
    chk("alu_a",      bus.alu_a,           e_a);
    chk("alu_b",      bus.alu_b,           e_b);
    chk("resp_valid", 32'(bus.resp_valid), e_rv);
    chk("resp_data",  bus.resp_data,       m_data);
    chk("busy",       32'(bus.busy),       32'(m_held));
    chk("rr_ptr",     32'(dut.rr_ptr_q),   32'(m_ptr));
    @(posedge clk);
    if (!rst_n) begin
      m_held = 0; m_id = 0; m_ptr = 0; m_data = 0; w = -1;
    end else if (w >= 0) begin
      m_data = ref_alu(bus.req_op[w*OW +: OW], bus.req_a[w*DW +: DW], bus.req_b[w*DW +: DW]);
      m_id   = w;
      m_held = 1;
      m_ptr  = (w + 1) % N;
    end else if (m_held && bus.resp_ready[m_id]) begin
      m_held = 0;
    end
    last_win = w;
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[i*OW +: OW] = op;
    bus.req_a[i*DW +: DW]  = a;
    bus.req_b[i*DW +: DW]  = b;
  endtask

  initial begin
    bit [N-1:0] pend;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.resp_ready = '0;
    bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    m_held = 0; m_id = 0; m_ptr = 0; m_data = 0; last_win = -1;
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 0);
    rst_n = 1'b1;

    // Single request: 5 + 7.
    set_req(0, ADD, 32'd5, 32'd7); bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("single_resp_data", bus.resp_data, 32'd12);
    bus.resp_ready = 2'b01;
    step();
    chk("single_busy_after", 32'(bus.busy), 0);

    // Contention from pointer 0.
    rst_n = 1'b0; bus.resp_ready = 2'b00; step(); rst_n = 1'b1;
    set_req(0, SUB, 32'd10, 32'd3); set_req(1, SLTU, 32'd3, 32'd10);
    bus.req_valid = 2'b11; bus.resp_ready = 2'b11;
    step();
    chk("cont_first_valid", 32'(bus.resp_valid), 32'h1);
    chk("cont_first_data", bus.resp_data, 32'd7);
    bus.req_valid = 2'b10;
    step();
    chk("cont_second_valid", 32'(bus.resp_valid), 32'h2);
    chk("cont_second_data", bus.resp_data, 32'd1);
    chk("cont_ptr", 32'(dut.rr_ptr_q), 0);
    bus.req_valid = 2'b00;
    step();

    // Fairness: both always valid, responses always taken.
    set_req(0, ADD, 32'd100, 32'd1); set_req(1, OR, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11; bus.resp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_resp_valid", 32'(bus.resp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("fair_resp_data", bus.resp_data, (k % 2 == 0) ? 32'd101 : 32'hFF);
    end
    bus.req_valid = 2'b00;
    step();

    // Backpressure on requester 1; requester 0 waits, its resp_ready is ignored.
    set_req(1, XOR, 32'hFFFF0000, 32'h0000FFFF); bus.req_valid = 2'b10; bus.resp_ready = 2'b00;
    step();
    set_req(0, ADD, 32'd2, 32'd3); bus.req_valid = 2'b01; bus.resp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_resp_data", bus.resp_data, 32'hFFFFFFFF);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'h2);
    end
    bus.resp_ready = 2'b10;
    step();
    chk("bp_release_data", bus.resp_data, 32'd5);
    bus.req_valid = 2'b00; bus.resp_ready = 2'b01;
    step();

    // Reset while a result is held.
    set_req(0, ADD, 32'd1, 32'd1); bus.req_valid = 2'b01; bus.resp_ready = 2'b00;
    step();
    bus.req_valid = 2'b00; rst_n = 1'b0;
    step();
    chk("rst_mid_valid", 32'(bus.resp_valid), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_data", bus.resp_data, 0);
    chk("rst_mid_ptr", 32'(dut.rr_ptr_q), 0);
    rst_n = 1'b1;
    set_req(1, SLL, 32'd1, 32'd36); bus.req_valid = 2'b10; bus.resp_ready = 2'b10;
    step();
    chk("rst_sll_data", bus.resp_data, 32'd16);
    bus.req_valid = 2'b00;
    step();

    // Idle for 10 cycles.
    bus.resp_ready = 2'b00;
    repeat (10) step();
    chk("idle_ptr", 32'(dut.rr_ptr_q), 0);
    chk("idle_alu_a", bus.alu_a, 0);

    // Randomized traffic obeying the hold-until-ready rule.
    pend = '0;
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, 3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom);
          pend[i] = 1'b1;
        end
      bus.req_valid = pend;
      bus.resp_ready = N'($urandom);
      step();
      if (last_win >= 0) pend[last_win] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
